// File: rtl/product_accumulator_pkg.sv
// Shared widths and state encoding for the accumulate half of the multiply-accumulate datapath.
package product_accumulator_pkg;

  localparam int PROD_W = 4;
  localparam int SUM_W  = 8;
  localparam int BATCH  = 4;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } acc_state_e;

endpackage

// File: rtl/product_accumulator_if.sv
// Product stream in, batch result out; the accumulator sits on the slave side.
interface product_accumulator_if #(
  parameter int IN_W  = 4,
  parameter int ACC_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_data, clear, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

  modport master (
    output in_valid, in_data, clear, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/product_accumulator.sv
// Sums fixed batches of COUNT unsigned products and presents each sum with a sticky carry flag.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int IN_W  = PROD_W,
  parameter int ACC_W = SUM_W,
  parameter int COUNT = BATCH
) (
  input logic                  clk,
  input logic                  rst_n,
  product_accumulator_if.slave bus
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  acc_state_e       state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [ACC_W-1:0] outSum_q;
  logic             outOvf_q;
  logic             outValid_q;

  logic [ACC_W:0]   prodExt;
  logic [ACC_W:0]   sum_d;

  // One extra bit on the adder captures the carry out of ACC_W.
  assign prodExt = {{(ACC_W + 1 - IN_W){1'b0}}, bus.in_data};
  assign sum_d   = {1'b0, acc_q} + prodExt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_ACC;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      outSum_q   <= '0;
      outOvf_q   <= 1'b0;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          // clear wins over a product offered in the same cycle.
          if (bus.clear) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
          end else if (bus.in_valid) begin
            if (cnt_q == LAST) begin
              outSum_q   <= sum_d[ACC_W-1:0];
              outOvf_q   <= ovf_q | sum_d[ACC_W];
              outValid_q <= 1'b1;
              state_q    <= ST_HOLD;
              acc_q      <= '0;
              cnt_q      <= '0;
              ovf_q      <= 1'b0;
            end else begin
              acc_q <= sum_d[ACC_W-1:0];
              ovf_q <= ovf_q | sum_d[ACC_W];
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= ST_ACC;
          end
        end
        default: state_q <= ST_ACC;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_ACC);
  assign bus.out_valid = outValid_q;
  assign bus.out_sum   = outSum_q;
  assign bus.out_ovf   = outOvf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed scenarios plus a randomized run against a batch-sum reference model.
module tb_product_accumulator;
  import product_accumulator_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int assertCount = 0;
  int failCount = 0;

  product_accumulator_if #(.IN_W(PROD_W), .ACC_W(SUM_W)) bus8 ();
  product_accumulator_if #(.IN_W(PROD_W), .ACC_W(5))     bus5 ();

  product_accumulator #(.IN_W(PROD_W), .ACC_W(SUM_W), .COUNT(BATCH)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8.slave)
  );

  product_accumulator #(.IN_W(PROD_W), .ACC_W(5), .COUNT(BATCH)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push8(input int d);
    bus8.in_valid = 1'b1;
    bus8.in_data  = 4'(d);
    tick();
    bus8.in_valid = 1'b0;
  endtask

  task automatic push5(input int d);
    bus5.in_valid = 1'b1;
    bus5.in_data  = 4'(d);
    tick();
    bus5.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    assertCount++; if (bus8.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %b expected 0", bus8.out_valid); end
    assertCount++; if (bus8.out_sum !== 8'd0) begin failCount++; $display("[TB] FAIL reset_sum: got %0d expected 0", bus8.out_sum); end
    assertCount++; if (bus8.out_ovf !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ovf: got %b expected 0", bus8.out_ovf); end
    assertCount++; if (bus8.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_ready: got %b expected 1", bus8.in_ready); end
    assertCount++; if (bus5.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_ready5: got %b expected 1", bus5.in_ready); end
  endtask

  task automatic test_basic_batch();
    bus8.out_ready = 1'b1;
    push8(9); push8(6); push8(3);
    assertCount++; if (bus8.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL basic_early_valid: got %b expected 0", bus8.out_valid); end
    push8(2);
    assertCount++; if (bus8.out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL basic_valid: got %b expected 1", bus8.out_valid); end
    assertCount++; if (bus8.out_sum !== 8'd20) begin failCount++; $display("[TB] FAIL basic_sum: got %0d expected 20", bus8.out_sum); end
    assertCount++; if (bus8.out_ovf !== 1'b0) begin failCount++; $display("[TB] FAIL basic_ovf: got %b expected 0", bus8.out_ovf); end
    assertCount++; if (bus8.in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL basic_hold_ready: got %b expected 0", bus8.in_ready); end
    tick();
    assertCount++; if (bus8.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL basic_valid_drop: got %b expected 0", bus8.out_valid); end
    assertCount++; if (bus8.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL basic_ready_back: got %b expected 1", bus8.in_ready); end
    assertCount++; if (bus8.out_sum !== 8'd20) begin failCount++; $display("[TB] FAIL basic_sum_retained: got %0d expected 20", bus8.out_sum); end
  endtask

  task automatic test_table_sweep();
    int prodTable[16] = '{0, 0, 0, 0, 0, 1, 2, 3, 0, 2, 4, 6, 0, 3, 6, 9};
    int expSums[4] = '{0, 6, 12, 18};
    bus8.out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 4; k++) push8(prodTable[b * 4 + k]);
      assertCount++; if (bus8.out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL sweep_valid[%0d]: got %b expected 1", b, bus8.out_valid); end
      assertCount++; if (bus8.out_sum !== 8'(expSums[b])) begin failCount++; $display("[TB] FAIL sweep_sum[%0d]: got %0d expected %0d", b, bus8.out_sum, expSums[b]); end
      assertCount++; if (bus8.out_ovf !== 1'b0) begin failCount++; $display("[TB] FAIL sweep_ovf[%0d]: got %b expected 0", b, bus8.out_ovf); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    bus8.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push8(9);
    bus8.in_valid = 1'b1;
    bus8.in_data  = 4'd5;
    for (int c = 0; c < 3; c++) begin
      assertCount++; if (bus8.out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", c, bus8.out_valid); end
      assertCount++; if (bus8.out_sum !== 8'd36) begin failCount++; $display("[TB] FAIL bp_sum[%0d]: got %0d expected 36", c, bus8.out_sum); end
      assertCount++; if (bus8.in_ready !== 1'b0) begin failCount++; $display("[TB] FAIL bp_ready[%0d]: got %b expected 0", c, bus8.in_ready); end
      tick();
    end
    bus8.out_ready = 1'b1;
    tick();
    assertCount++; if (bus8.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL bp_release: got %b expected 0", bus8.out_valid); end
    assertCount++; if (bus8.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL bp_ready_back: got %b expected 1", bus8.in_ready); end
    tick();
    bus8.in_valid = 1'b0;
    push8(1); push8(1); push8(1);
    assertCount++; if (bus8.out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL bp_next_valid: got %b expected 1", bus8.out_valid); end
    assertCount++; if (bus8.out_sum !== 8'd8) begin failCount++; $display("[TB] FAIL bp_next_sum: got %0d expected 8", bus8.out_sum); end
    tick();
  endtask

  task automatic test_overflow();
    bus5.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) push5(9);
    assertCount++; if (bus5.out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL ovf_valid: got %b expected 1", bus5.out_valid); end
    assertCount++; if (bus5.out_sum !== 5'd4) begin failCount++; $display("[TB] FAIL ovf_sum: got %0d expected 4", bus5.out_sum); end
    assertCount++; if (bus5.out_ovf !== 1'b1) begin failCount++; $display("[TB] FAIL ovf_flag: got %b expected 1", bus5.out_ovf); end
    tick();
    for (int k = 0; k < 4; k++) push5(1);
    assertCount++; if (bus5.out_sum !== 5'd4) begin failCount++; $display("[TB] FAIL ovf_next_sum: got %0d expected 4", bus5.out_sum); end
    assertCount++; if (bus5.out_ovf !== 1'b0) begin failCount++; $display("[TB] FAIL ovf_cleared: got %b expected 0", bus5.out_ovf); end
    tick();
  endtask

  task automatic test_clear();
    bus8.out_ready = 1'b1;
    push8(7); push8(7);
    bus8.clear    = 1'b1;
    bus8.in_valid = 1'b1;
    bus8.in_data  = 4'd7;
    assertCount++; if (bus8.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL clear_ready: got %b expected 1", bus8.in_ready); end
    tick();
    bus8.clear    = 1'b0;
    bus8.in_valid = 1'b0;
    push8(1); push8(2); push8(3); push8(4);
    assertCount++; if (bus8.out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL clear_valid: got %b expected 1", bus8.out_valid); end
    assertCount++; if (bus8.out_sum !== 8'd10) begin failCount++; $display("[TB] FAIL clear_sum: got %0d expected 10", bus8.out_sum); end
    bus8.out_ready = 1'b0;
    bus8.clear     = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      assertCount++; if (bus8.out_valid !== 1'b1) begin failCount++; $display("[TB] FAIL clear_hold_valid[%0d]: got %b expected 1", c, bus8.out_valid); end
      assertCount++; if (bus8.out_sum !== 8'd10) begin failCount++; $display("[TB] FAIL clear_hold_sum[%0d]: got %0d expected 10", c, bus8.out_sum); end
    end
    bus8.clear     = 1'b0;
    bus8.out_ready = 1'b1;
    tick();
    assertCount++; if (bus8.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL clear_delivered: got %b expected 0", bus8.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus8.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push8(9);
    assertCount++; if (bus8.out_sum !== 8'd36) begin failCount++; $display("[TB] FAIL rstmid_pre_sum: got %0d expected 36", bus8.out_sum); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    assertCount++; if (bus8.out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL rstmid_valid: got %b expected 0", bus8.out_valid); end
    assertCount++; if (bus8.out_sum !== 8'd0) begin failCount++; $display("[TB] FAIL rstmid_sum: got %0d expected 0", bus8.out_sum); end
    assertCount++; if (bus8.in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL rstmid_ready: got %b expected 1", bus8.in_ready); end
    bus8.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) push8(1);
    assertCount++; if (bus8.out_sum !== 8'd4) begin failCount++; $display("[TB] FAIL rstmid_next_sum: got %0d expected 4", bus8.out_sum); end
    tick();
  endtask

  task automatic test_random();
    int batchQ[$];
    bit hold = 1'b0;
    int expSum = 0;
    bit expOvf = 1'b0;
    for (int c = 0; c < 300; c++) begin
      bit inV;
      bit clr;
      bit ordy;
      int d;
      inV  = ($urandom_range(0, 9) < 7);
      clr  = ($urandom_range(0, 19) == 0);
      ordy = 1'($urandom_range(0, 1));
      d    = $urandom_range(0, 15);
      bus8.in_valid  = inV;
      bus8.in_data   = 4'(d);
      bus8.clear     = clr;
      bus8.out_ready = ordy;
      assertCount++; if (bus8.in_ready !== !hold) begin failCount++; $display("[TB] FAIL rand_ready[%0d]: got %b expected %b", c, bus8.in_ready, !hold); end
      assertCount++; if (bus8.out_valid !== hold) begin failCount++; $display("[TB] FAIL rand_valid[%0d]: got %b expected %b", c, bus8.out_valid, hold); end
      if (hold) begin
        assertCount++; if (bus8.out_sum !== 8'(expSum)) begin failCount++; $display("[TB] FAIL rand_sum[%0d]: got %0d expected %0d", c, bus8.out_sum, expSum); end
        assertCount++; if (bus8.out_ovf !== expOvf) begin failCount++; $display("[TB] FAIL rand_ovf[%0d]: got %b expected %b", c, bus8.out_ovf, expOvf); end
      end
      if (hold) begin
        if (ordy) hold = 1'b0;
      end else if (clr) begin
        batchQ.delete();
      end else if (inV) begin
        batchQ.push_back(d);
        if (batchQ.size() == BATCH) begin
          int total = 0;
          foreach (batchQ[i]) total += batchQ[i];
          expSum = total % (1 << SUM_W);
          expOvf = (total >= (1 << SUM_W));
          hold = 1'b1;
          batchQ.delete();
        end
      end
      tick();
    end
    bus8.in_valid  = 1'b0;
    bus8.clear     = 1'b0;
    bus8.out_ready = 1'b1;
    tick();
  endtask

  initial begin
    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.clear = 1'b0; bus8.out_ready = 1'b1;
    bus5.in_valid = 1'b0; bus5.in_data = '0; bus5.clear = 1'b0; bus5.out_ready = 1'b1;
    $display("[TB] starting product_accumulator bench");
    test_reset();
    test_basic_batch();
    test_table_sweep();
    test_backpressure();
    test_overflow();
    test_clear();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
